// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline boundary registers.
package riscv_pipe_pkg;

  localparam int PC_W      = 32;
  localparam int INSTR_W   = 32;
  localparam int PAYLOAD_W = PC_W + INSTR_W;

  // addi x0, x0, 0 -- the canonical RISC-V NOP
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Payload shown by an empty stage: pc = 0 carrying a NOP
  localparam logic [PAYLOAD_W-1:0] BUBBLE_DEFAULT = {{PC_W{1'b0}}, NOP_INSTR};

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  function automatic logic [PAYLOAD_W-1:0] pack_if_id(input logic [PC_W-1:0] pc,
                                                      input logic [INSTR_W-1:0] instr);
    if_id_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Pipeline boundary register with optional skid entry. The main register
// feeds downstream; the skid register absorbs one extra entry so that
// in_ready can be computed from registered state only.
module pipe_stage
  import riscv_pipe_pkg::*;
#(
  parameter int                DATA_W = PAYLOAD_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_DEFAULT),
  parameter bit                SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pause,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bubble,
  output logic [1:0]        count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              do_accept;
  logic              do_release;

  // Handshake and output view derived from the held entries; a flush drops
  // whatever would otherwise be accepted this cycle.
  always_comb begin
    if (SKID) begin
      in_ready = !skid_valid && !pause;
    end else begin
      in_ready = (!main_valid || out_ready) && !pause;
    end
    out_valid  = main_valid && !pause;
    do_accept  = in_valid && in_ready && !flush;
    do_release = out_valid && out_ready;
    out_data   = main_valid ? main_data : BUBBLE;
    out_bubble = !main_valid;
    count      = {1'b0, main_valid} + {1'b0, skid_valid};
  end

  // Entry storage: reset beats flush beats pause; otherwise the skid entry
  // is promoted as main leaves and new data fills the oldest free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= BUBBLE;
      skid_data  <= BUBBLE;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!pause) begin
      if (do_release) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (do_accept) begin
          main_data <= in_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (do_accept) begin
        if (!main_valid) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (SKID) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits; the IF/ID use packs {pc[31:0], instr[31:0]}.
REQ-002 Parameter BUBBLE, default 64'h0000_0000_0000_0013: payload presented when the stage is empty, i.e. pc=0 with instr=addi x0,x0,0.
REQ-003 Parameter SKID, default 1: 1 gives a 2-entry stage (main + skid); 0 gives a 1-entry stage.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  discards all held entries (branch/jump redirect).
REQ-007 pause  in  1  hazard-unit stall; freezes the stage.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_ready  out  1  stage accepts in_data this cycle.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  out_data holds a real entry.
REQ-012 out_ready  in  1  downstream consumes the entry this cycle.
REQ-013 out_data  out  DATA_W  oldest held entry, or BUBBLE when the stage is empty.
REQ-014 out_bubble  out  1  high when out_data equals BUBBLE because the stage is empty.
REQ-015 count  out  2  number of held entries: 0..2, or 0..1 when SKID=0.

Function
REQ-016 Accept occurs when in_valid && in_ready; release occurs when out_valid && out_ready.
REQ-017 With SKID=1, in_ready SHALL be !skid_full && !pause, driven from registered state only, with no combinational path from out_ready.
REQ-018 With SKID=0, in_ready SHALL be (!main_valid || out_ready) && !pause, a permitted combinational path.
REQ-019 Latency SHALL be 1 cycle: an entry accepted at edge N appears on out_data after edge N when the stage was empty.
REQ-020 Throughput SHALL be one entry per cycle while out_ready=1 and pause=0.
REQ-021 Order SHALL be strict FIFO; the skid entry moves to main on the same edge that main is released.
REQ-022 On accept with release while count=1, main takes in_data and count stays 1.
REQ-023 When out_ready=0 and main is full, an accepted entry goes to skid and count becomes 2; in_ready drops on the next cycle.
REQ-024 With count=2, an accept is impossible; a release moves skid to main and count becomes 1.
REQ-025 pause=1 SHALL hold every register, force in_ready=0 and out_valid=0, and keep out_data stable.
REQ-026 flush=1 SHALL on the next edge clear both entries (count=0, out_data=BUBBLE, out_bubble=1) and drop any same-cycle accept.
REQ-027 flush SHALL take priority over pause, and rst SHALL take priority over flush.
REQ-028 out_valid SHALL be 0 whenever count=0, and out_bubble SHALL equal (count==0).

Reset
REQ-029 rst SHALL on the next edge set count=0, out_valid=0, out_data=BUBBLE, out_bubble=1 and in_ready=1 (pause permitting), and discard entries held mid-operation.
REQ-030 No output SHALL be undefined after the first reset edge.

Structure
REQ-031 A shared package riscv_pipe_pkg SHALL hold NOP_INSTR=32'h0000_0013, the default PC/instr widths and the BUBBLE default.
REQ-032 No sub-module; the stage is one module with the main and skid registers, instantiated per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Verification
REQ-033 Reset then idle -> out_data=64'h13, out_bubble=1, count=0, in_ready=1.
REQ-034 Stream {pc=0x0,0x4,0x8} with out_ready=1 -> each appears one cycle later, back-to-back, with count=1.
REQ-035 out_ready=0 while pushing 0x10 and 0x14 -> count=2 and in_ready=0; then out_ready=1 -> 0x10 then 0x14 in order.
REQ-036 pause=1 for 3 cycles holding 0x20 -> out_data stays 0x20, out_valid=0, no accept; after release -> 0x20 delivered once.
REQ-037 flush together with in_valid(0x30) at count=2 -> next cycle count=0, out_data=BUBBLE, 0x30 never emitted.
REQ-038 SKID=0 instance with out_ready toggling 1,0,1 -> in_ready follows out_ready in the same cycle, no loss or duplication.
